// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin arbiter that shares one byte-level I2C
// engine among NREQ requesters and runs START, ADDR, DATA, STOP per grant.
// Ports:
//   CLK, RST                        clock, synchronous active-high reset
//   req/req_addr/req_rw/req_wdata   per-requester request bundle
//   gnt, done, busy                 one-hot grant, completion pulse, busy
//   rsp_rdata/rsp_nack/rsp_timeout  response of the last transaction
//   eng_valid/eng_cmd/eng_tx/eng_tx_ack/eng_ready  engine command channel
//   eng_done/eng_rx/eng_ack_in      engine completion and returned data
module i2c_txn_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0]   req_rw,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_nack,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              eng_valid,
    output logic [1:0]        eng_cmd,
    output logic [7:0]        eng_tx,
    output logic              eng_tx_ack,
    input  logic              eng_ready,
    input  logic              eng_done,
    input  logic [7:0]        eng_rx,
    input  logic              eng_ack_in
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_DATA,
        S_STOP,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic            wait_q, wait_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [6:0]      addr_q, addr_d;
    logic            rw_q, rw_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            nack_q, nack_d;
    logic            tmo_q, tmo_d;

    logic [6:0]      addr_arr  [NREQ];
    logic [7:0]      wdata_arr [NREQ];
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   scan_idx;
    logic            step_done;
    logic            step_tmo;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[7*i +: 7];
        assign wdata_arr[i] = req_wdata[8*i +: 8];
    end

    // First set request at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IW'((int'(ptr_q) + k) % NREQ);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        nack_d    = nack_q;
        tmo_d     = tmo_q;
        eng_valid = 1'b0;
        eng_cmd   = CMD_START;
        eng_tx    = 8'h00;
        done      = '0;
        // Done in the acceptance cycle is ignored: only the wait phase counts.
        step_done = wait_q && eng_done;
        step_tmo  = !step_done && (cnt_q == CW'(TIMEOUT - 1));

        if (state_q != S_IDLE && state_q != S_RESP) begin
            eng_valid = !wait_q;
            cnt_d     = cnt_q + CW'(1);
            if (!wait_q && eng_ready) begin
                wait_d = 1'b1;
            end
            if (step_done || step_tmo) begin
                cnt_d  = '0;
                wait_d = 1'b0;
            end
            if (step_tmo) begin
                tmo_d   = 1'b1;
                state_d = (state_q == S_STOP) ? S_RESP : S_STOP;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    addr_d         = addr_arr[win_idx];
                    rw_d           = req_rw[win_idx];
                    wdata_d        = wdata_arr[win_idx];
                    rdata_d        = 8'h00;
                    nack_d         = 1'b0;
                    tmo_d          = 1'b0;
                    cnt_d          = '0;
                    wait_d         = 1'b0;
                    ptr_d          = (win_idx == IW'(NREQ - 1)) ?
                                     '0 : win_idx + IW'(1);
                    state_d        = S_START;
                end
            end
            S_START: begin
                eng_cmd = CMD_START;
                if (step_done) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                eng_cmd = CMD_WRITE;
                eng_tx  = {addr_q, rw_q};
                if (step_done) begin
                    if (eng_ack_in) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                eng_cmd = rw_q ? CMD_READ : CMD_WRITE;
                eng_tx  = rw_q ? 8'h00 : wdata_q;
                if (step_done) begin
                    if (rw_q) begin
                        rdata_d = eng_rx;
                    end else begin
                        nack_d = eng_ack_in;
                    end
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                eng_cmd = CMD_STOP;
                if (step_done) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                done    = gnt_q;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            wait_q  <= 1'b0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            nack_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            nack_q  <= nack_d;
            tmo_q   <= tmo_d;
        end
    end

    assign gnt         = gnt_q;
    assign busy        = (state_q != S_IDLE);
    assign rsp_rdata   = rdata_q;
    assign rsp_nack    = nack_q;
    assign rsp_timeout = tmo_q;
    // Single-byte reads always end with a master NACK.
    assign eng_tx_ack  = 1'b1;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: directed bench for i2c_txn_arbiter with a small
// engine model that logs accepted commands and answers with eng_done.
module tb_i2c_txn_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 15;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [27:0]     req_addr = '0;
    logic [NREQ-1:0] req_rw = '0;
    logic [31:0]     req_wdata = '0;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic [7:0]      rsp_rdata;
    logic            rsp_nack;
    logic            rsp_timeout;
    logic            busy;
    logic            eng_valid;
    logic [1:0]      eng_cmd;
    logic [7:0]      eng_tx;
    logic            eng_tx_ack;
    logic            eng_ready = 1'b1;
    logic            eng_done = 1'b0;
    logic [7:0]      eng_rx = '0;
    logic            eng_ack_in = 1'b0;

    always #5 CLK = ~CLK;

    i2c_txn_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_addr(req_addr),
        .req_rw(req_rw), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .rsp_timeout(rsp_timeout), .busy(busy), .eng_valid(eng_valid),
        .eng_cmd(eng_cmd), .eng_tx(eng_tx), .eng_tx_ack(eng_tx_ack),
        .eng_ready(eng_ready), .eng_done(eng_done), .eng_rx(eng_rx),
        .eng_ack_in(eng_ack_in)
    );

    int n_tot = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Engine model: done two cycles after acceptance unless told to hang.
    logic        hang_en = 1'b0;
    logic [7:0]  hang_byte = '0;
    logic        nack_en = 1'b0;
    logic [7:0]  nack_byte = '0;
    logic [7:0]  rx_val = '0;
    logic [10:0] log_q[$];
    int          log_t[$];
    int          cyc = 0;
    logic        e_pend = 1'b0;
    int          e_dly = 0;
    logic [1:0]  e_cmd = '0;
    logic [7:0]  e_tx = '0;

    always @(posedge CLK) begin : eng_model
        logic       acc;
        logic [1:0] c;
        logic [7:0] t;
        cyc = cyc + 1;
        acc = eng_valid && eng_ready && !RST;
        c   = eng_cmd;
        t   = eng_tx;
        if (acc) begin
            log_q.push_back({eng_tx_ack, eng_cmd, eng_tx});
            log_t.push_back(cyc);
        end
        #1;
        eng_done   = 1'b0;
        eng_ack_in = 1'b0;
        eng_rx     = 8'h00;
        if (RST) begin
            e_pend = 1'b0;
        end else if (acc) begin
            e_pend = 1'b1;
            e_dly  = 2;
            e_cmd  = c;
            e_tx   = t;
        end else if (e_pend) begin
            e_dly = e_dly - 1;
            if (e_dly == 0) begin
                e_pend = 1'b0;
                if (!(hang_en && e_cmd == 2'b01 && e_tx == hang_byte)) begin
                    eng_done = 1'b1;
                    if (e_cmd == 2'b10) eng_rx = rx_val;
                    if (e_cmd == 2'b01 && nack_en && e_tx == nack_byte)
                        eng_ack_in = 1'b1;
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [6:0] a,
                           input logic rw, input logic [7:0] wd);
        req_addr[7*i +: 7]  = a;
        req_rw[i]           = rw;
        req_wdata[8*i +: 8] = wd;
    endtask

    task automatic wait_done(output logic [3:0] d, output logic ok);
        d  = '0;
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge CLK);
            if (|done) begin
                d  = done;
                ok = 1'b1;
            end
        end
    endtask

    task automatic wait_gnt(input logic [3:0] want, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge CLK);
            if (gnt == want) ok = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] d;
        logic       ok;
        logic [3:0] e;
        int         gap;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_outs", {gnt, done, busy, eng_valid, eng_cmd, eng_tx,
              rsp_rdata, rsp_nack, rsp_timeout}, 32'h0);
        RST = 1'b0;

        // Write to 0x50
        log_q.delete(); log_t.delete();
        set_req(0, 7'h50, 1'b0, 8'hA5);
        req = 4'b0001;
        @(negedge CLK);
        check("t1_gnt_lat", gnt, 4'b0001);
        check("t1_busy", busy, 1);
        req = 4'b0000;
        wait_done(d, ok);
        check("t1_done_seen", ok, 1);
        check("t1_done", d, 4'b0001);
        check("t1_gnt_held", gnt, 4'b0001);
        check("t1_nack", rsp_nack, 0);
        check("t1_tmo", rsp_timeout, 0);
        @(negedge CLK);
        check("t1_idle", {gnt, busy, done}, 0);
        check("t1_ncmd", log_q.size(), 4);
        check("t1_c0", log_q[0][9:8], 2'b00);
        check("t1_c1", log_q[1][9:0], {2'b01, 8'hA0});
        check("t1_c2", log_q[2][9:0], {2'b01, 8'hA5});
        check("t1_c3", log_q[3][9:8], 2'b11);

        // Read from 0x3C
        log_q.delete(); log_t.delete();
        set_req(2, 7'h3C, 1'b1, 8'h00);
        rx_val = 8'h5E;
        req = 4'b0100;
        wait_gnt(4'b0100, ok);
        check("t2_gnt", ok, 1);
        req = 4'b0000;
        wait_done(d, ok);
        check("t2_done", d, 4'b0100);
        check("t2_rdata", rsp_rdata, 8'h5E);
        check("t2_ncmd", log_q.size(), 4);
        check("t2_c1", log_q[1][9:0], {2'b01, 8'h79});
        check("t2_c2", log_q[2][10:8], 3'b110);
        check("t2_c3", log_q[3][9:8], 2'b11);

        // Address NACK
        log_q.delete(); log_t.delete();
        nack_en = 1'b1;
        nack_byte = 8'h44;
        set_req(1, 7'h22, 1'b0, 8'h99);
        req = 4'b0010;
        wait_gnt(4'b0010, ok);
        check("t3_gnt", ok, 1);
        req = 4'b0000;
        wait_done(d, ok);
        check("t3_done", d, 4'b0010);
        check("t3_nack", rsp_nack, 1);
        check("t3_rdata_clr", rsp_rdata, 8'h00);
        check("t3_ncmd", log_q.size(), 3);
        check("t3_c1", log_q[1][9:0], {2'b01, 8'h44});
        check("t3_c2", log_q[2][9:8], 2'b11);
        nack_en = 1'b0;

        // Round robin from a fresh pointer
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 7'h40 + 7'(i), 1'b0, 8'h11);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_done(d, ok);
            e = 4'b0001 << (i % 4);
            check($sformatf("rr%0d", i), d, e);
        end
        req = 4'b0000;
        @(negedge CLK);

        // DATA step never completes
        log_q.delete(); log_t.delete();
        hang_en = 1'b1;
        hang_byte = 8'h77;
        set_req(3, 7'h10, 1'b0, 8'h77);
        req = 4'b1000;
        wait_gnt(4'b1000, ok);
        check("t5_gnt", ok, 1);
        req = 4'b0000;
        wait_done(d, ok);
        check("t5_done", d, 4'b1000);
        check("t5_tmo", rsp_timeout, 1);
        check("t5_nack", rsp_nack, 0);
        check("t5_ncmd", log_q.size(), 4);
        check("t5_c1", log_q[1][9:0], {2'b01, 8'h20});
        check("t5_c2", log_q[2][9:0], {2'b01, 8'h77});
        check("t5_c3", log_q[3][9:8], 2'b11);
        gap = (log_q.size() == 4) ? log_t[3] - log_t[2] : 0;
        check("t5_gap", (gap >= TMO && gap <= TMO + 1), 1);
        hang_en = 1'b0;

        // Reset during ADDR, pointer returns to 0
        set_req(0, 7'h12, 1'b0, 8'h33);
        set_req(1, 7'h11, 1'b0, 8'h22);
        req = 4'b0001;
        wait_gnt(4'b0001, ok);
        check("t6_gnt0", ok, 1);
        req = 4'b0000;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge CLK);
            if (eng_valid && eng_cmd == 2'b01) ok = 1'b1;
        end
        check("t6_in_addr", ok, 1);
        RST = 1'b1;
        @(negedge CLK);
        check("t6_rst_outs", {gnt, done, busy, eng_valid, eng_cmd, eng_tx,
              rsp_rdata, rsp_nack, rsp_timeout}, 32'h0);
        RST = 1'b0;
        req = 4'b0011;
        @(negedge CLK);
        check("t6_ptr0", gnt, 4'b0001);
        req = 4'b0010;
        wait_done(d, ok);
        check("t6_done0", d, 4'b0001);
        wait_gnt(4'b0010, ok);
        check("t6_gnt1", ok, 1);
        req = 4'b0000;
        wait_done(d, ok);
        check("t6_done1", d, 4'b0010);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
